sparse_mac_pe: RTL and testbench
================================

# sparse_mac_pe

Parametrised sparse multiply-accumulate processing element for the 1D output-stationary systolic array. Each input beat carries N_LANES sparse matrix entries `{val, rowIdx, tag}` and one dense vector element. Every non-zero lane is multiplied by the vector element and accumulated into a per-tag accumulator. Overlapping non-zero lanes are serialised rather than dropped, and completed rows are emitted through a valid/ready output port. The arithmetic uses the existing `fp_multiplier` and `fp_adder` combinational FP32 units.

## Interface
- N_LANES, 2: lanes per input beat (≥1)
- IDX_W, 12: row index width
- TAG_W, 1: tag width; the block holds 2^TAG_W accumulators
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  beat valid
- in_ready  out  1  beat accepted when in_valid & in_ready
- in_val  in  32*N_LANES  FP32 values, lane k at [32k+31:32k]
- in_rowIdx  in  IDX_W*N_LANES  row index per lane
- in_tag  in  TAG_W*N_LANES  tag per lane
- in_vec  in  32  dense vector element for the beat
- flush_req  in  1  level; requests draining of all accumulators
- out_valid  out  1  completed row available
- out_ready  in  1  consumer accepts when out_valid & out_ready
- out_sum  out  32  accumulated FP32 sum
- out_rowIdx  out  IDX_W  row of out_sum
- out_tag  out  TAG_W  tag of out_sum
- overlap  out  1  one-cycle pulse: accepted beat had more than one non-zero lane
- flush_done  out  1  one-cycle pulse at end of flush
- busy  out  1  beat register, product stage or output register occupied, or FSM not in RUN

## Operation
- Zero test: a lane is non-zero when `val[30:0] != 0` (±0 both count as zero).
- Beat register B: holds the accepted beat plus a pending mask of its non-zero lanes.
  - An all-zero beat is retired in one cycle and produces no product.
- Select stage: each cycle, the lowest-index pending lane goes through `fp_multiplier` with the vector element. Product, rowIdx and tag are registered into P, and that lane's pending bit is cleared.
- Accumulate stage, reading P, with acc[tag] = {valid, rowIdx, sum}:
  - acc invalid: load {1, rowIdx, product}. The adder is bypassed, because `fp_adder` cannot handle a zero operand.
  - acc valid, same rowIdx: sum ← fp_adder(sum, product).
  - acc valid, different rowIdx: move the old {sum, rowIdx, tag} into output register O, then load the product. This requires O empty or draining this cycle; otherwise stall.
- Stall propagation: an accumulate stall holds P; a held P holds the select stage; a held select stage holds B.
- in_ready = FSM in RUN & (B empty | (one pending bit left & select not stalled)).
- FSM states:
  - RUN: normal operation. If flush_req=1, go to DRAIN; in_ready is low from the next cycle.
  - DRAIN: wait until B and P are empty, then go to FLUSH with tag pointer 0.
  - FLUSH: for each tag in ascending order, if acc valid, move it to O when O is free and invalidate it. Advance the pointer. Invalid entries take 1 cycle each. After the last tag, go to DONE.
  - DONE: pulse flush_done for 1 cycle, then go to RUN (a new flush requires flush_req to be re-evaluated).
- Output register O: holds until out_valid & out_ready. A transfer and a new load may happen in the same cycle.

## Timing
- Reset: all outputs 0, except in_ready, which is 1 one cycle after release. B, P and O are empty, every acc is invalid, the FSM is in RUN.
- Reset asserted mid-operation clears everything immediately; partial sums are discarded.
- Beat accepted at edge E0:
  - Lane products enter P at E1, E1+1, … in order of increasing lane index.
  - Each product is accumulated one edge after entering P.
  - overlap is high for the cycle after E0 when two or more lanes are non-zero.
- A beat with k non-zero lanes holds in_ready low for k−1 cycles.
- Emit latency: a row change seen in P at edge E appears on out_valid after E+1.
- Back-to-back same-tag products need no bubble, because the read-modify-write completes in one cycle.
- With out_ready held low and O full, the next row change stalls the pipeline. in_ready falls within 2 cycles and no data is lost.
- flush_req asserted together with in_valid & in_ready: the beat is accepted, then the FSM enters DRAIN.

## Configuration
- OVERLAP_STATS_EN defined: adds port `overlap_cnt  out  16`. It increments, saturating at 0xFFFF, on each accepted beat with ≥2 non-zero lanes. It resets to 0.
- Not defined: the port and counter are absent; overlap behaviour is otherwise identical.

## Test plan
- Accumulate then emit:
  - Stimulus, all with tag0, lane1=0:
    - lane0 {0x3F800000, row 5}, vec 0x40000000
    - lane0 {0x40000000, row 5}, vec 0x40000000
    - lane0 {0x3F800000, row 6}
  - Required response: out {sum 0x40C00000, row 5, tag 0}.
- Overlap, vec 0x40000000:
  - Stimulus: lane0 {0x3F800000, row 1, tag 0}, lane1 {0x40400000, row 2, tag 1}.
  - Required response: overlap=1 for 1 cycle, in_ready low for 1 cycle; flush then emits tag0 {0x40000000, row 1} followed by tag1 {0x40C00000, row 2}.
- Backpressure:
  - Stimulus: out_ready=0 and three row changes on tag0.
  - Required response: O holds the first row, in_ready drops. After out_ready=1, rows emerge in order with none lost or duplicated.
- Flush with empty and valid accumulators:
  - Stimulus: only acc1 is valid.
  - Required response: one output (tag 1), flush_done pulses once, in_ready is low throughout, and the FSM returns to RUN.
- Reset mid-beat:
  - Stimulus: assert reset_n=0 while B holds 2 pending lanes.
  - Required response: all outputs 0 at once. After release, a fresh row starts from the bare product (no stale sum).
- OVERLAP_STATS_EN:
  - Stimulus: 3 overlapping beats and 2 single-lane beats.
  - Required response: overlap_cnt=3. Also force 0xFFFF and confirm it saturates.

Source files
------------

// File: rtl/sparse_mac_pe.sv
// sparse_mac_pe: sparse multiply-accumulate PE for the 1D output-stationary
// systolic array. Each beat carries N_LANES sparse entries {val,rowIdx,tag}
// plus one dense vector element. Non-zero lanes are serialised through one
// FP32 multiplier, then accumulated into a per-tag accumulator. Completed
// rows leave through a valid/ready output register.
//
// Optional feature: define OVERLAP_STATS_EN to add the 16-bit saturating
// overlap_cnt output.
//
// Ports:
//   clk, reset_n             clock, async active-low reset
//   in_valid/in_ready        input beat handshake
//   in_val/in_rowIdx/in_tag  per-lane sparse entries, lane k in slice k
//   in_vec                   dense vector element for the beat
//   flush_req                level request to drain all accumulators
//   out_valid/out_ready      output handshake
//   out_sum/out_rowIdx/out_tag  completed row
//   overlap                  pulse: accepted beat had >1 non-zero lane
//   flush_done               pulse at end of flush
//   busy                     pipeline occupied or FSM not in RUN
//   overlap_cnt              (OVERLAP_STATS_EN only) overlapping-beat count

// FP32 multiply, round-to-nearest-even. Zero/denormal inputs give zero,
// exponent overflow gives infinity, underflow flushes to zero.
module fp_multiplier (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] p_o
);
  logic [47:0]       prod;
  logic [24:0]       m;
  logic signed [9:0] e;
  logic              g, st, s;

  always_comb begin
    prod = 48'({1'b1, a_i[22:0]}) * 48'({1'b1, b_i[22:0]});
    s    = a_i[31] ^ b_i[31];
    if (prod[47]) begin
      m  = {1'b0, prod[47:24]};
      g  = prod[23];
      st = |prod[22:0];
      e  = $signed({2'b0, a_i[30:23]}) + $signed({2'b0, b_i[30:23]}) - 10'sd126;
    end else begin
      m  = {1'b0, prod[46:23]};
      g  = prod[22];
      st = |prod[21:0];
      e  = $signed({2'b0, a_i[30:23]}) + $signed({2'b0, b_i[30:23]}) - 10'sd127;
    end
    m = m + {24'd0, g & (st | m[0])};
    if (m[24]) begin
      m = m >> 1;
      e = e + 10'sd1;
    end
    p_o = {s, e[7:0], m[22:0]};
    if (a_i[30:23] == 8'd0 || b_i[30:23] == 8'd0 || e <= 10'sd0)
      p_o = {s, 31'd0};
    else if (e >= 10'sd255)
      p_o = {s, 8'hFF, 23'd0};
  end
endmodule

// FP32 add, round-to-nearest-even. Both operands must be non-zero normals;
// the caller bypasses the adder whenever one side would be zero.
module fp_adder (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] s_o
);
  logic [31:0]       big, sml;
  logic [7:0]        d;
  logic [26:0]       mbig, msml, msh, v;
  logic [27:0]       sum28;
  logic [24:0]       m;
  logic [4:0]        lz;
  logic              found, stk;
  logic signed [9:0] e;

  always_comb begin
    if (a_i[30:0] >= b_i[30:0]) begin big = a_i; sml = b_i; end
    else                        begin big = b_i; sml = a_i; end
    d     = big[30:23] - sml[30:23];
    mbig  = {1'b1, big[22:0], 3'b000};
    msml  = {1'b1, sml[22:0], 3'b000};
    sum28 = '0;
    lz    = '0;
    found = 1'b0;
    // Align the smaller operand; shifted-out bits collapse into a sticky bit.
    if (d >= 8'd27) begin
      msh = '0;
      stk = 1'b1;
    end else begin
      msh = msml >> d;
      stk = |(msml & ((27'd1 << d) - 27'd1));
    end
    msh[0] = msh[0] | stk;
    e = $signed({2'b0, big[30:23]});
    if (big[31] == sml[31]) begin
      sum28 = {1'b0, mbig} + {1'b0, msh};
      if (sum28[27]) begin
        v = {sum28[27:2], sum28[1] | sum28[0]};
        e = e + 10'sd1;
      end else begin
        v = sum28[26:0];
      end
    end else begin
      v = mbig - msh;
      for (int i = 26; i >= 0; i--) begin
        if (!found && v[i]) begin
          lz    = 5'(26 - i);
          found = 1'b1;
        end
      end
      v = v << lz;
      e = e - $signed({5'b0, lz});
    end
    m = {1'b0, v[26:3]} + {24'd0, v[2] & ((|v[1:0]) | v[3])};
    if (m[24]) begin
      m = m >> 1;
      e = e + 10'sd1;
    end
    s_o = {big[31], e[7:0], m[22:0]};
    if (v == 27'd0 || e <= 10'sd0) s_o = 32'd0;
    else if (e >= 10'sd255)        s_o = {big[31], 8'hFF, 23'd0};
  end
endmodule

module sparse_mac_pe #(
  parameter int N_LANES = 2,
  parameter int IDX_W   = 12,
  parameter int TAG_W   = 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [32*N_LANES-1:0]    in_val,
  input  logic [IDX_W*N_LANES-1:0] in_rowIdx,
  input  logic [TAG_W*N_LANES-1:0] in_tag,
  input  logic [31:0]              in_vec,
  input  logic                     flush_req,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_sum,
  output logic [IDX_W-1:0]         out_rowIdx,
  output logic [TAG_W-1:0]         out_tag,
  output logic                     overlap,
`ifdef OVERLAP_STATS_EN
  output logic [15:0]              overlap_cnt,
`endif
  output logic                     flush_done,
  output logic                     busy
);
  localparam int NT    = 1 << TAG_W;
  localparam int SEL_W = (N_LANES > 1) ? $clog2(N_LANES) : 1;
  localparam logic [TAG_W-1:0] LAST = TAG_W'(NT - 1);

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_FLUSH, S_DONE} state_e;

  state_e state_q, state_d;
  logic [TAG_W-1:0] ptr_q, ptr_d;
  logic             rdy_en_q;

  // Beat register
  logic [N_LANES-1:0]            b_pend_q, b_pend_d;
  logic [N_LANES-1:0][31:0]      b_val_q, b_val_d;
  logic [N_LANES-1:0][IDX_W-1:0] b_row_q, b_row_d;
  logic [N_LANES-1:0][TAG_W-1:0] b_tag_q, b_tag_d;
  logic [31:0]                   b_vec_q, b_vec_d;

  // Product register
  logic             p_vld_q, p_vld_d;
  logic [31:0]      p_prod_q, p_prod_d;
  logic [IDX_W-1:0] p_row_q, p_row_d;
  logic [TAG_W-1:0] p_tag_q, p_tag_d;

  // Accumulators
  logic [NT-1:0]            acc_vld_q, acc_vld_d;
  logic [NT-1:0][IDX_W-1:0] acc_row_q, acc_row_d;
  logic [NT-1:0][31:0]      acc_sum_q, acc_sum_d;

  // Output register
  logic             o_vld_q, o_vld_d;
  logic [31:0]      o_sum_q, o_sum_d;
  logic [IDX_W-1:0] o_row_q, o_row_d;
  logic [TAG_W-1:0] o_tag_q, o_tag_d;

  logic overlap_q, overlap_d;

  logic [N_LANES-1:0] lane_nz;
  logic [SEL_W-1:0]   sel;
  logic               sel_found, sel_fire, b_empty, pend_one;
  logic               o_free, acc_stall, accept, multi_nz, adv;
  logic [31:0]        mul_p, add_s;

  // A lane counts as zero for both +0 and -0.
  for (genvar k = 0; k < N_LANES; k++) begin : g_nz
    assign lane_nz[k] = |in_val[32*k +: 31];
  end

  assign multi_nz = (lane_nz & (lane_nz - 1'b1)) != '0;
  assign b_empty  = (b_pend_q == '0);
  assign pend_one = !b_empty && ((b_pend_q & (b_pend_q - 1'b1)) == '0);
  assign o_free   = !o_vld_q || out_ready;
  // A row change needs O; if O stays full the whole front end holds.
  assign acc_stall = p_vld_q && acc_vld_q[p_tag_q] &&
                     (acc_row_q[p_tag_q] != p_row_q) && !o_free;
  assign sel_fire  = !b_empty && !acc_stall;
  assign in_ready  = rdy_en_q && (state_q == S_RUN) &&
                     (b_empty || (pend_one && !acc_stall));
  assign accept    = in_valid && in_ready;

  always_comb begin
    sel       = '0;
    sel_found = 1'b0;
    for (int k = 0; k < N_LANES; k++) begin
      if (!sel_found && b_pend_q[k]) begin
        sel       = SEL_W'(k);
        sel_found = 1'b1;
      end
    end
  end

  fp_multiplier u_mul (.a_i(b_val_q[sel]), .b_i(b_vec_q), .p_o(mul_p));
  fp_adder      u_add (.a_i(acc_sum_q[p_tag_q]), .b_i(p_prod_q), .s_o(add_s));

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    b_pend_d  = b_pend_q;
    b_val_d   = b_val_q;
    b_row_d   = b_row_q;
    b_tag_d   = b_tag_q;
    b_vec_d   = b_vec_q;
    p_vld_d   = p_vld_q;
    p_prod_d  = p_prod_q;
    p_row_d   = p_row_q;
    p_tag_d   = p_tag_q;
    acc_vld_d = acc_vld_q;
    acc_row_d = acc_row_q;
    acc_sum_d = acc_sum_q;
    o_vld_d   = o_vld_q;
    o_sum_d   = o_sum_q;
    o_row_d   = o_row_q;
    o_tag_d   = o_tag_q;
    overlap_d = accept && multi_nz;
    adv       = 1'b0;

    if (o_vld_q && out_ready) o_vld_d = 1'b0;

    // Select stage: lowest pending lane into P.
    if (!acc_stall) begin
      p_vld_d = sel_fire;
      if (sel_fire) begin
        p_prod_d      = mul_p;
        p_row_d       = b_row_q[sel];
        p_tag_d       = b_tag_q[sel];
        b_pend_d[sel] = 1'b0;
      end
    end

    if (accept) begin
      b_pend_d = lane_nz;
      b_val_d  = in_val;
      b_row_d  = in_rowIdx;
      b_tag_d  = in_tag;
      b_vec_d  = in_vec;
    end

    // Accumulate stage. A fresh row loads the product directly so the
    // adder never sees a zero operand.
    if (p_vld_q && !acc_stall) begin
      if (acc_vld_q[p_tag_q] && acc_row_q[p_tag_q] == p_row_q) begin
        acc_sum_d[p_tag_q] = add_s;
      end else begin
        if (acc_vld_q[p_tag_q]) begin
          o_vld_d = 1'b1;
          o_sum_d = acc_sum_q[p_tag_q];
          o_row_d = acc_row_q[p_tag_q];
          o_tag_d = p_tag_q;
        end
        acc_vld_d[p_tag_q] = 1'b1;
        acc_row_d[p_tag_q] = p_row_q;
        acc_sum_d[p_tag_q] = p_prod_q;
      end
    end

    case (state_q)
      S_RUN:   if (flush_req) state_d = S_DRAIN;
      S_DRAIN: if (b_empty && !p_vld_q) begin
        state_d = S_FLUSH;
        ptr_d   = '0;
      end
      S_FLUSH: begin
        // P is empty here, so O is only contended with the consumer.
        adv = 1'b1;
        if (acc_vld_q[ptr_q]) begin
          if (o_free) begin
            o_vld_d          = 1'b1;
            o_sum_d          = acc_sum_q[ptr_q];
            o_row_d          = acc_row_q[ptr_q];
            o_tag_d          = ptr_q;
            acc_vld_d[ptr_q] = 1'b0;
          end else begin
            adv = 1'b0;
          end
        end
        if (adv) begin
          if (ptr_q == LAST) state_d = S_DONE;
          else               ptr_d   = ptr_q + TAG_W'(1);
        end
      end
      S_DONE:  state_d = S_RUN;
      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_RUN;
      ptr_q     <= '0;
      rdy_en_q  <= 1'b0;
      b_pend_q  <= '0;
      b_val_q   <= '0;
      b_row_q   <= '0;
      b_tag_q   <= '0;
      b_vec_q   <= '0;
      p_vld_q   <= 1'b0;
      p_prod_q  <= '0;
      p_row_q   <= '0;
      p_tag_q   <= '0;
      acc_vld_q <= '0;
      acc_row_q <= '0;
      acc_sum_q <= '0;
      o_vld_q   <= 1'b0;
      o_sum_q   <= '0;
      o_row_q   <= '0;
      o_tag_q   <= '0;
      overlap_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      rdy_en_q  <= 1'b1;
      b_pend_q  <= b_pend_d;
      b_val_q   <= b_val_d;
      b_row_q   <= b_row_d;
      b_tag_q   <= b_tag_d;
      b_vec_q   <= b_vec_d;
      p_vld_q   <= p_vld_d;
      p_prod_q  <= p_prod_d;
      p_row_q   <= p_row_d;
      p_tag_q   <= p_tag_d;
      acc_vld_q <= acc_vld_d;
      acc_row_q <= acc_row_d;
      acc_sum_q <= acc_sum_d;
      o_vld_q   <= o_vld_d;
      o_sum_q   <= o_sum_d;
      o_row_q   <= o_row_d;
      o_tag_q   <= o_tag_d;
      overlap_q <= overlap_d;
    end
  end

`ifdef OVERLAP_STATS_EN
  logic [15:0] ovl_cnt_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                      ovl_cnt_q <= '0;
    else if (accept && multi_nz && ovl_cnt_q != 16'hFFFF) ovl_cnt_q <= ovl_cnt_q + 16'd1;
  end
  assign overlap_cnt = ovl_cnt_q;
`endif

  assign out_valid  = o_vld_q;
  assign out_sum    = o_sum_q;
  assign out_rowIdx = o_row_q;
  assign out_tag    = o_tag_q;
  assign overlap    = overlap_q;
  assign flush_done = (state_q == S_DONE);
  assign busy       = !b_empty || p_vld_q || o_vld_q || (state_q != S_RUN);
endmodule

// File: tb/tb_sparse_mac_pe.sv
// Bench for sparse_mac_pe: directed scenarios plus a randomized run scored
// against an integer-valued reference model (all values are small integers,
// so FP32 results are exact and the model can use plain int arithmetic).
module tb_sparse_mac_pe;
  localparam int N  = 2;
  localparam int IW = 12;
  localparam int TW = 1;
  localparam int NT = 1 << TW;
  localparam int OW = 32 + IW + TW;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [32*N-1:0] in_val = '0;
  logic [IW*N-1:0] in_rowIdx = '0;
  logic [TW*N-1:0] in_tag = '0;
  logic [31:0]     in_vec = '0;
  logic            flush_req = 1'b0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [31:0]     out_sum;
  logic [IW-1:0]   out_rowIdx;
  logic [TW-1:0]   out_tag;
  logic            overlap, flush_done, busy;
`ifdef OVERLAP_STATS_EN
  logic [15:0]     overlap_cnt;
`endif

  int n_chk = 0, n_fail = 0, ovl_seen = 0;
  logic [OW-1:0] got_q[$];
  logic [OW-1:0] exp_q[$];
  bit rnd_on = 1'b0;

  sparse_mac_pe #(.N_LANES(N), .IDX_W(IW), .TAG_W(TW)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_val(in_val), .in_rowIdx(in_rowIdx), .in_tag(in_tag), .in_vec(in_vec),
    .flush_req(flush_req), .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_rowIdx(out_rowIdx), .out_tag(out_tag),
    .overlap(overlap),
`ifdef OVERLAP_STATS_EN
    .overlap_cnt(overlap_cnt),
`endif
    .flush_done(flush_done), .busy(busy));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) got_q.push_back({out_sum, out_rowIdx, out_tag});
    if (overlap) ovl_seen++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [OW-1:0] pk(input logic [31:0] s, input int r, input int t);
    return {s, IW'(r), TW'(t)};
  endfunction

  // Exact FP32 encoding of a non-negative integer below 2^24.
  function automatic logic [31:0] i2f(input int n);
    int p;
    logic [31:0] u;
    if (n == 0) return 32'd0;
    p = 0;
    for (int i = 0; i < 31; i++) if (((n >> i) & 1) != 0) p = i;
    u = 32'(n) << (23 - p);
    return {1'b0, 8'(127 + p), u[22:0]};
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Entered and left just after a rising edge.
  task automatic send(input logic [32*N-1:0] v, input logic [IW*N-1:0] r,
                      input logic [TW*N-1:0] t, input logic [31:0] vec);
    bit ok = 1'b0;
    in_val = v; in_rowIdx = r; in_tag = t; in_vec = vec; in_valid = 1'b1;
    for (int c = 0; c < 200 && !ok; c++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!ok) chk("beat_accept", 64'(ok), 64'd1);
  endtask

  task automatic flush(output int nd, output int nrdy);
    bit fin = 1'b0;
    nd = 0; nrdy = 0;
    flush_req = 1'b1;
    cyc(1);
    flush_req = 1'b0;
    for (int c = 0; c < 300 && !fin; c++) begin
      @(negedge clk);
      if (in_ready) nrdy++;
      if (flush_done) begin nd++; fin = 1'b1; end
    end
    repeat (3) begin
      @(negedge clk);
      if (flush_done) nd++;
    end
    cyc(1);
  endtask

  // Reference model: per-tag accumulator in integer units.
  bit mv[NT];
  int mr[NT], ms[NT];

  task automatic mdl_prod(input int t, input int r, input int p);
    if (mv[t] && mr[t] == r) ms[t] += p;
    else begin
      if (mv[t]) exp_q.push_back(pk(i2f(ms[t]), mr[t], t));
      mv[t] = 1'b1; mr[t] = r; ms[t] = p;
    end
  endtask

  task automatic mdl_flush();
    for (int t = 0; t < NT; t++) if (mv[t]) begin
      exp_q.push_back(pk(i2f(ms[t]), mr[t], t));
      mv[t] = 1'b0;
    end
  endtask

  initial begin
    int nd, nrdy, ovl_base, ovl_exp, lim;
    bit fin;
    logic [32*N-1:0] v;
    logic [IW*N-1:0] r;
    logic [TW*N-1:0] t;
`ifdef OVERLAP_STATS_EN
    logic [15:0] cbase;
`endif

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_out_sum", 64'(out_sum), 64'd0);
    reset_n = 1'b1;
    #1 chk("rdy_at_release", 64'(in_ready), 64'd0);
    @(negedge clk);
    chk("rdy_after_release", 64'(in_ready), 64'd1);
    cyc(1);

    // Accumulate then emit
    got_q.delete();
    send({32'h0, 32'h3F800000}, {12'd0, 12'd5}, 2'b00, 32'h40000000);
    send({32'h0, 32'h40000000}, {12'd0, 12'd5}, 2'b00, 32'h40000000);
    send({32'h0, 32'h3F800000}, {12'd0, 12'd6}, 2'b00, 32'h40000000);
    cyc(5);
    chk("acc_cnt", 64'(got_q.size()), 64'd1);
    if (got_q.size() > 0) chk("acc_row5", 64'(got_q[0]), 64'(pk(32'h40C00000, 5, 0)));
    flush(nd, nrdy);
    chk("acc_flush_done", 64'(nd), 64'd1);
    if (got_q.size() > 1) chk("acc_row6", 64'(got_q[1]), 64'(pk(32'h40000000, 6, 0)));
    else chk("acc_flush_cnt", 64'(got_q.size()), 64'd2);

    // Overlap
    got_q.delete();
    send({32'h40400000, 32'h3F800000}, {12'd2, 12'd1}, 2'b10, 32'h40000000);
    @(negedge clk);
    chk("ovl_pulse", 64'(overlap), 64'd1);
    chk("ovl_rdy_low", 64'(in_ready), 64'd0);
    @(negedge clk);
    chk("ovl_pulse_end", 64'(overlap), 64'd0);
    chk("ovl_rdy_back", 64'(in_ready), 64'd1);
    cyc(4);
    flush(nd, nrdy);
    chk("ovl_out_cnt", 64'(got_q.size()), 64'd2);
    if (got_q.size() == 2) begin
      chk("ovl_out_tag0", 64'(got_q[0]), 64'(pk(32'h40000000, 1, 0)));
      chk("ovl_out_tag1", 64'(got_q[1]), 64'(pk(32'h40C00000, 2, 1)));
    end

    // Backpressure
    got_q.delete();
    out_ready = 1'b0;
    for (int k = 10; k <= 13; k++)
      send({32'h0, i2f(k - 9)}, {12'd0, 12'(k)}, 2'b00, 32'h3F800000);
    cyc(3);
    @(negedge clk);
    chk("bp_rdy_low", 64'(in_ready), 64'd0);
    chk("bp_o_full", 64'(out_valid), 64'd1);
    chk("bp_o_row", 64'(out_rowIdx), 64'd10);
    cyc(1);
    out_ready = 1'b1;
    cyc(6);
    flush(nd, nrdy);
    chk("bp_cnt", 64'(got_q.size()), 64'd4);
    for (int i = 0; i < got_q.size() && i < 4; i++)
      chk("bp_row", 64'(got_q[i]), 64'(pk(i2f(i + 1), 10 + i, 0)));

    // Flush with only acc1 valid (lane0 is -0)
    got_q.delete();
    send({32'h40000000, 32'h80000000}, {12'd3, 12'd9}, 2'b10, 32'h40000000);
    cyc(4);
    flush(nd, nrdy);
    chk("fl_done_once", 64'(nd), 64'd1);
    chk("fl_rdy_low", 64'(nrdy), 64'd0);
    chk("fl_cnt", 64'(got_q.size()), 64'd1);
    if (got_q.size() > 0) chk("fl_out", 64'(got_q[0]), 64'(pk(32'h40800000, 3, 1)));
    @(negedge clk);
    chk("fl_run_rdy", 64'(in_ready), 64'd1);
    chk("fl_idle", 64'(busy), 64'd0);
    cyc(1);

    // Reset mid-beat with a stale partial sum in acc0
    send({32'h0, 32'h3F800000}, {12'd0, 12'd7}, 2'b00, 32'h40000000);
    cyc(4);
    send({32'h3F800000, 32'h3F800000}, {12'd8, 12'd7}, 2'b10, 32'h40000000);
    reset_n = 1'b0;
    #1;
    chk("mr_overlap", 64'(overlap), 64'd0);
    chk("mr_busy", 64'(busy), 64'd0);
    chk("mr_in_ready", 64'(in_ready), 64'd0);
    chk("mr_out_valid", 64'(out_valid), 64'd0);
    chk("mr_flush_done", 64'(flush_done), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    cyc(2);
    got_q.delete();
    send({32'h0, 32'h3F800000}, {12'd0, 12'd7}, 2'b00, 32'h40400000);
    send({32'h0, 32'h3F800000}, {12'd0, 12'd9}, 2'b00, 32'h3F800000);
    cyc(5);
    chk("mr_cnt", 64'(got_q.size()), 64'd1);
    if (got_q.size() > 0) chk("mr_fresh", 64'(got_q[0]), 64'(pk(32'h40400000, 7, 0)));
    flush(nd, nrdy);

`ifdef OVERLAP_STATS_EN
    cbase = overlap_cnt;
    for (int i = 0; i < 3; i++)
      send({32'h3F800000, 32'h3F800000}, {12'd20, 12'd20}, 2'b10, 32'h3F800000);
    for (int i = 0; i < 2; i++)
      send({32'h0, 32'h3F800000}, {12'd0, 12'd20}, 2'b00, 32'h3F800000);
    cyc(3);
    chk("ovl_cnt", 64'(overlap_cnt), 64'(cbase + 16'd3));
    force dut.ovl_cnt_q = 16'hFFFF;
    cyc(1);
    release dut.ovl_cnt_q;
    send({32'h3F800000, 32'h3F800000}, {12'd20, 12'd20}, 2'b10, 32'h3F800000);
    cyc(3);
    chk("ovl_cnt_sat", 64'(overlap_cnt), 64'hFFFF);
    flush(nd, nrdy);
`endif

    // Randomized run
    got_q.delete();
    exp_q.delete();
    for (int i = 0; i < NT; i++) mv[i] = 1'b0;
    ovl_base = ovl_seen;
    ovl_exp  = 0;
    rnd_on   = 1'b1;
    fork
      while (rnd_on) begin
        @(posedge clk);
        #1 out_ready = ($urandom_range(0, 3) != 0);
      end
    join_none
    for (int it = 0; it < 200; it++) begin
      int vi, lv[N], lr[N], lt[N], nzc;
      vi  = $urandom_range(1, 4);
      nzc = 0;
      for (int k = 0; k < N; k++) begin
        int x;
        x = $urandom_range(0, 9);
        lr[k] = $urandom_range(0, 3);
        lt[k] = $urandom_range(0, NT - 1);
        lv[k] = (x <= 2) ? 0 : x - 2;
        v[32*k +: 32] = (x == 1) ? 32'h80000000 : i2f(lv[k]);
        r[IW*k +: IW] = IW'(lr[k]);
        t[TW*k +: TW] = TW'(lt[k]);
        if (lv[k] != 0) begin
          nzc++;
          mdl_prod(lt[k], lr[k], lv[k] * vi);
        end
      end
      if (nzc >= 2) ovl_exp++;
      send(v, r, t, i2f(vi));
      if (it % 50 == 49) begin
        mdl_flush();
        flush(nd, nrdy);
        chk("rnd_flush_done", 64'(nd), 64'd1);
      end
    end
    rnd_on = 1'b0;
    @(posedge clk);
    #2 out_ready = 1'b1;
    fin = 1'b0;
    lim = 0;
    while (!fin && lim < 100) begin
      @(negedge clk);
      if (!busy) fin = 1'b1;
      lim++;
    end
    chk("rnd_idle", 64'(fin), 64'd1);
    chk("rnd_overlaps", 64'(ovl_seen - ovl_base), 64'(ovl_exp));
    chk("rnd_cnt", 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk("rnd_out", 64'(got_q[i]), 64'(exp_q[i]));

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
